// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU op classes, R-type funct codes, mult/div FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // ALU operation classes decoded by the control unit
    localparam logic [3:0] ALUOP_ADD   = 4'd0;
    localparam logic [3:0] ALUOP_AND   = 4'd1;
    localparam logic [3:0] ALUOP_OR    = 4'd2;
    localparam logic [3:0] ALUOP_XOR   = 4'd3;
    localparam logic [3:0] ALUOP_SLT   = 4'd4;
    localparam logic [3:0] ALUOP_SLTU  = 4'd5;
    localparam logic [3:0] ALUOP_LUI   = 4'd6;
    localparam logic [3:0] ALUOP_RTYPE = 4'd7;

    // R-type function codes
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_SLLV  = 6'h04;
    localparam logic [5:0] FUNCT_SRLV  = 6'h06;
    localparam logic [5:0] FUNCT_SRAV  = 6'h07;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    // Instructions that start the iterative unit
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // Instructions that must wait while the unit owns HI/LO
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return is_md_funct(f) ||
               (f == FUNCT_MFHI) || (f == FUNCT_MFLO) ||
               (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bundle, forwarding sources and EX results grouped for the execute stage.
// Latency: n/a (wires only).
// Backpressure: ex_stall is the only flow-control signal, driven by the slave side.
// Ports: master = pipeline/driver side, slave = ex_stage.
interface ex_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] ex_dato_1;
    logic [DATA_W-1:0] ex_dato_2;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [5:0]        ex_function_code;
    logic [DATA_W-1:0] ex_extended_beq_offset;
    logic              ex_reg_dst;
    logic              ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic              ex_isJal;
    logic              ex_jalSel;
    logic [DATA_W-1:0] ex_pc_plus_8;
    logic [DATA_W-1:0] mem_fwd_data;
    logic [4:0]        mem_fwd_rd;
    logic              mem_fwd_we;
    logic [DATA_W-1:0] wb_fwd_data;
    logic [4:0]        wb_fwd_rd;
    logic              wb_fwd_we;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [4:0]        ex_write_reg;
    logic              ex_stall;
    logic              md_busy;

    modport master (
        output ex_dato_1, ex_dato_2, ex_rs, ex_rt, ex_rd, ex_function_code,
               ex_extended_beq_offset, ex_reg_dst, ex_alu_src, ex_alu_op,
               ex_isJal, ex_jalSel, ex_pc_plus_8,
               mem_fwd_data, mem_fwd_rd, mem_fwd_we,
               wb_fwd_data, wb_fwd_rd, wb_fwd_we,
        input  ex_alu_result, ex_store_data, ex_write_reg, ex_stall, md_busy
    );

    modport slave (
        input  ex_dato_1, ex_dato_2, ex_rs, ex_rt, ex_rd, ex_function_code,
               ex_extended_beq_offset, ex_reg_dst, ex_alu_src, ex_alu_op,
               ex_isJal, ex_jalSel, ex_pc_plus_8,
               mem_fwd_data, mem_fwd_rd, mem_fwd_we,
               wb_fwd_data, wb_fwd_rd, wb_fwd_we,
        output ex_alu_result, ex_store_data, ex_write_reg, ex_stall, md_busy
    );
endinterface

// File: rtl/ex_stage_mult_div_unit.sv
// Iterative multiply/divide (shift-add / restoring, one bit per cycle) owning HI/LO.
// Latency: issue edge + MD_ITER cycles in MUL/DIV + 1 cycle in FIX; HI/LO update on the edge leaving FIX.
// Backpressure: start/mthi/mtlo are only honoured in IDLE; md_busy tells the caller to hold dependents.
// Ports: clk, reset (async active-low), clk_en (freeze), start/start_div/start_signed + op_a/op_b,
//        mthi_we/mtlo_we + mt_data, hi/lo results, md_busy.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MD_ITER = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic              start_div,
    input  logic              start_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              md_busy
);
    localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

    md_state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   acc_hi;   // product high half / partial remainder
    logic [DATA_W-1:0]   acc_lo;   // multiplier being consumed / dividend->quotient
    logic [DATA_W-1:0]   operand;  // multiplicand or divisor magnitude
    logic                neg_q;    // negate product / quotient
    logic                neg_r;    // negate remainder (dividend sign)
    logic                op_div;

    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;

    assign abs_a = (start_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    assign abs_b = (start_signed && op_b[DATA_W-1]) ? -op_b : op_b;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, operand};
    // Partial remainder stays below 2*divisor, so the top bit of the difference is a clean borrow
    assign div_ge    = ~div_diff[DATA_W];

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        md_busy   = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = start_div ? DIV : MUL;
            MUL:     if (cnt == CNT_LAST) state_nxt = FIX;
            DIV:     if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            op_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= start_div ? abs_a : abs_b;
                        operand <= start_div ? abs_b : abs_a;
                        neg_q   <= start_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                        neg_r   <= start_signed & op_a[DATA_W-1];
                        op_div  <= start_div;
                    end else begin
                        if (mthi_we) hi <= mt_data;
                        if (mtlo_we) lo <= mt_data;
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
                    cnt              <= cnt + CNT_W'(1);
                end
                DIV: begin
                    acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                    acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (op_div) begin
                        // Divide by zero: all-ones quotient; remainder path already holds the dividend
                        lo <= (operand == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, JAL/JALR link, mult/div with HI/LO.
// Latency: ALU path combinational; mult/div results land in HI/LO MD_ITER+1 cycles after issue.
// Backpressure: ex_stall (combinational) holds HI/LO-dependent instructions while mult/div is busy.
// Ports: clk, reset (async active-low), clk_en (freeze), bus (ex_stage_if.slave: ID/EX operands,
//        MEM/WB forwarding sources, ex_alu_result/ex_store_data/ex_write_reg/ex_stall/md_busy).
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MD_ITER = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    ex_stage_if.slave  bus
);
    logic [DATA_W-1:0] fwd_a, fwd_b, op_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] hi, lo;
    logic [4:0]        shamt, vshamt;
    logic              rtype;
    logic              md_start;
    logic              md_busy;
    logic              stall;
    logic [5:0]        funct;

    assign funct = bus.ex_function_code;

    // MEM beats WB; register 0 is never forwarded
    always_comb begin
        fwd_a = bus.ex_dato_1;
        if (bus.mem_fwd_we && bus.mem_fwd_rd != 5'd0 && bus.mem_fwd_rd == bus.ex_rs)
            fwd_a = bus.mem_fwd_data;
        else if (bus.wb_fwd_we && bus.wb_fwd_rd != 5'd0 && bus.wb_fwd_rd == bus.ex_rs)
            fwd_a = bus.wb_fwd_data;

        fwd_b = bus.ex_dato_2;
        if (bus.mem_fwd_we && bus.mem_fwd_rd != 5'd0 && bus.mem_fwd_rd == bus.ex_rt)
            fwd_b = bus.mem_fwd_data;
        else if (bus.wb_fwd_we && bus.wb_fwd_rd != 5'd0 && bus.wb_fwd_rd == bus.ex_rt)
            fwd_b = bus.wb_fwd_data;
    end

    assign op_b   = bus.ex_alu_src ? bus.ex_extended_beq_offset : fwd_b;
    assign shamt  = bus.ex_extended_beq_offset[10:6];
    assign vshamt = fwd_a[4:0];

    assign rtype    = (bus.ex_alu_op == ALUOP_RTYPE) && !bus.ex_isJal;
    assign md_start = rtype && is_md_funct(funct);
    assign stall    = md_busy && rtype && is_hilo_funct(funct);

    always_comb begin
        alu_out = '0;
        case (bus.ex_alu_op)
            ALUOP_ADD:  alu_out = fwd_a + op_b;
            ALUOP_AND:  alu_out = fwd_a & op_b;
            ALUOP_OR:   alu_out = fwd_a | op_b;
            ALUOP_XOR:  alu_out = fwd_a ^ op_b;
            ALUOP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            ALUOP_SLTU: alu_out = {{(DATA_W-1){1'b0}}, fwd_a < op_b};
            ALUOP_LUI:  alu_out = bus.ex_extended_beq_offset << 16;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: alu_out = fwd_a + op_b;
                    FUNCT_SUB, FUNCT_SUBU: alu_out = fwd_a - op_b;
                    FUNCT_AND:  alu_out = fwd_a & op_b;
                    FUNCT_OR:   alu_out = fwd_a | op_b;
                    FUNCT_XOR:  alu_out = fwd_a ^ op_b;
                    FUNCT_NOR:  alu_out = ~(fwd_a | op_b);
                    FUNCT_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                    FUNCT_SLTU: alu_out = {{(DATA_W-1){1'b0}}, fwd_a < op_b};
                    FUNCT_SLL:  alu_out = op_b << shamt;
                    FUNCT_SRL:  alu_out = op_b >> shamt;
                    FUNCT_SRA:  alu_out = $unsigned($signed(op_b) >>> shamt);
                    FUNCT_SLLV: alu_out = op_b << vshamt;
                    FUNCT_SRLV: alu_out = op_b >> vshamt;
                    FUNCT_SRAV: alu_out = $unsigned($signed(op_b) >>> vshamt);
                    FUNCT_MFHI: alu_out = hi;
                    FUNCT_MFLO: alu_out = lo;
                    default:    alu_out = '0;
                endcase
            end
            default: alu_out = '0;
        endcase
    end

    assign bus.ex_alu_result = bus.ex_isJal ? bus.ex_pc_plus_8 : alu_out;
    assign bus.ex_store_data = fwd_b;
    assign bus.ex_write_reg  = bus.ex_isJal ? (bus.ex_jalSel ? bus.ex_rd : 5'd31)
                                            : (bus.ex_reg_dst ? bus.ex_rd : bus.ex_rt);
    assign bus.ex_stall      = stall;
    assign bus.md_busy       = md_busy;

    mult_div_unit #(
        .DATA_W  (DATA_W),
        .MD_ITER (MD_ITER)
    ) u_md (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .start        (md_start),
        .start_div    ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU)),
        .start_signed ((funct == FUNCT_MULT) || (funct == FUNCT_DIV)),
        .op_a         (fwd_a),
        .op_b         (fwd_b),
        .mthi_we      (rtype && (funct == FUNCT_MTHI) && !stall),
        .mtlo_we      (rtype && (funct == FUNCT_MTLO) && !stall),
        .mt_data      (fwd_a),
        .hi           (hi),
        .lo           (lo),
        .md_busy      (md_busy)
    );

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors, a behavioural model compared every cycle,
// and literal expectations for forwarding, link, mult/div results, stall length, reset and freeze.
module tb_ex_stage;
    import mips_pkg::*;

    localparam int W    = 32;
    localparam int ITER = 32;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    logic cmp_on = 1'b0;

    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(W)) bus ();

    ex_stage #(.DATA_W(W), .MD_ITER(ITER)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    int          m_left = 0;   // cycles until HI/LO are replaced; >0 means busy

    function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] raw);
        if (bus.mem_fwd_we && bus.mem_fwd_rd != 0 && bus.mem_fwd_rd == src) return bus.mem_fwd_data;
        if (bus.wb_fwd_we && bus.wb_fwd_rd != 0 && bus.wb_fwd_rd == src) return bus.wb_fwd_data;
        return raw;
    endfunction

    function automatic logic m_is_rtype();
        return bus.ex_alu_op == ALUOP_RTYPE && !bus.ex_isJal;
    endfunction

    function automatic logic m_stall();
        logic [5:0] f;
        f = bus.ex_function_code;
        return (m_left > 0) && m_is_rtype() &&
               (f == 6'h10 || f == 6'h11 || f == 6'h12 || f == 6'h13 ||
                f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B);
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] a, rt, b, imm;
        int sh, vsh;
        a   = m_fwd(bus.ex_rs, bus.ex_dato_1);
        rt  = m_fwd(bus.ex_rt, bus.ex_dato_2);
        imm = bus.ex_extended_beq_offset;
        b   = bus.ex_alu_src ? imm : rt;
        sh  = int'(imm[10:6]);
        vsh = int'(a[4:0]);
        if (bus.ex_isJal) return bus.ex_pc_plus_8;
        case (bus.ex_alu_op)
            ALUOP_ADD:  return a + b;
            ALUOP_AND:  return a & b;
            ALUOP_OR:   return a | b;
            ALUOP_XOR:  return a ^ b;
            ALUOP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUOP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALUOP_LUI:  return {imm[15:0], 16'h0000};
            ALUOP_RTYPE: begin
                case (bus.ex_function_code)
                    6'h20, 6'h21: return a + b;
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: return (a < b) ? 32'd1 : 32'd0;
                    6'h00: return b << sh;
                    6'h02: return b >> sh;
                    6'h03: return $unsigned($signed(b) >>> sh);
                    6'h04: return b << vsh;
                    6'h06: return b >> vsh;
                    6'h07: return $unsigned($signed(b) >>> vsh);
                    6'h10: return m_hi;
                    6'h12: return m_lo;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] m_wreg();
        if (bus.ex_isJal) return bus.ex_jalSel ? bus.ex_rd : 5'd31;
        return bus.ex_reg_dst ? bus.ex_rd : bus.ex_rt;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] a, b;
        int          ia, ib;
        longint      la, lb, ps;
        logic [63:0] pu;
        if (!reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (clk_en) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end else if (m_is_rtype()) begin
                a  = m_fwd(bus.ex_rs, bus.ex_dato_1);
                b  = m_fwd(bus.ex_rt, bus.ex_dato_2);
                ia = a;
                ib = b;
                case (bus.ex_function_code)
                    6'h18: begin
                        la = ia; lb = ib; ps = la * lb;
                        {p_hi, p_lo} = ps; m_left = ITER + 1;
                    end
                    6'h19: begin
                        pu = {32'd0, a} * {32'd0, b};
                        {p_hi, p_lo} = pu; m_left = ITER + 1;
                    end
                    6'h1A: begin
                        if (b == 0) begin
                            p_lo = 32'hFFFF_FFFF; p_hi = a;
                        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = 32'd0;
                        end else begin
                            p_lo = ia / ib; p_hi = ia % ib;
                        end
                        m_left = ITER + 1;
                    end
                    6'h1B: begin
                        if (b == 0) begin
                            p_lo = 32'hFFFF_FFFF; p_hi = a;
                        end else begin
                            p_lo = a / b; p_hi = a % b;
                        end
                        m_left = ITER + 1;
                    end
                    6'h11: m_hi = a;
                    6'h13: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model alu_result", bus.ex_alu_result, m_result());
            chk("model store_data", bus.ex_store_data, m_fwd(bus.ex_rt, bus.ex_dato_2));
            chk("model write_reg", {27'd0, bus.ex_write_reg}, {27'd0, m_wreg()});
            chk("model ex_stall", {31'd0, bus.ex_stall}, {31'd0, m_stall()});
            chk("model md_busy", {31'd0, bus.md_busy}, {31'd0, (m_left > 0)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nop();
        bus.ex_dato_1 = 0; bus.ex_dato_2 = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
        bus.ex_function_code = 0; bus.ex_extended_beq_offset = 0;
        bus.ex_reg_dst = 0; bus.ex_alu_src = 1; bus.ex_alu_op = ALUOP_ADD;
        bus.ex_isJal = 0; bus.ex_jalSel = 0; bus.ex_pc_plus_8 = 0;
        bus.mem_fwd_data = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_we = 0;
        bus.wb_fwd_data = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_we = 0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        nop();
        bus.ex_alu_op = ALUOP_RTYPE; bus.ex_alu_src = 0; bus.ex_reg_dst = 1;
        bus.ex_function_code = f;
        bus.ex_rs = rs; bus.ex_rt = rt; bus.ex_rd = rd;
        bus.ex_dato_1 = a; bus.ex_dato_2 = b;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, bus.ex_alu_result, exp);
        next();
    endtask

    // Issue a mult/div, hold MFHI behind it, count stall cycles, then read HI and LO.
    // gate_at >= 0 drops clk_en for 5 cycles once that many stall cycles have been seen.
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_stall, input int gate_at);
        int   cnt;
        int   gate_left;
        logic done;
        cnt = 0; gate_left = 0; done = 1'b0;
        rtype(f, 5'd1, 5'd2, 5'd0, a, b);
        next();
        rtype(FUNCT_MFHI, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        for (int i = 0; i < 120 && !done; i++) begin
            @(negedge clk);
            if (bus.ex_stall) begin
                cnt++;
                next();
                if (gate_left > 0) begin
                    gate_left--;
                    if (gate_left == 0) clk_en = 1'b1;
                end else if (gate_at >= 0 && cnt == gate_at) begin
                    clk_en = 1'b0;
                    gate_left = 5;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk({name, " completed"}, {31'd0, done}, 32'd1);
        chk({name, " stall cycles"}, 32'(cnt), 32'(exp_stall));
        chk({name, " HI"}, bus.ex_alu_result, exp_hi);
        next();
        rtype(FUNCT_MFLO, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        look({name, " LO"}, exp_lo);
        nop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        clk_en = 1'b1;
        nop();
        cmp_on = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset md_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("reset ex_stall", {31'd0, bus.ex_stall}, 32'd0);
        next();
        rtype(FUNCT_MFHI, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        look("reset HI", 32'd0);
        reset = 1'b1;
        nop();
        next();

        // Forwarding priority and r0 suppression
        rtype(FUNCT_ADDU, 5'd5, 5'd0, 5'd3, 32'h111, 32'd0);
        bus.mem_fwd_rd = 5; bus.mem_fwd_data = 32'h10; bus.mem_fwd_we = 1;
        bus.wb_fwd_rd  = 5; bus.wb_fwd_data  = 32'h20; bus.wb_fwd_we  = 1;
        look("fwd mem priority", 32'h10);
        bus.mem_fwd_we = 0;
        look("fwd wb", 32'h20);
        rtype(FUNCT_ADDU, 5'd0, 5'd0, 5'd3, 32'h7, 32'd0);
        bus.mem_fwd_rd = 0; bus.mem_fwd_data = 32'h10; bus.mem_fwd_we = 1;
        look("fwd r0 ignored", 32'h7);
        rtype(FUNCT_OR, 5'd1, 5'd6, 5'd3, 32'd0, 32'h55);
        bus.wb_fwd_rd = 6; bus.wb_fwd_data = 32'hABCD; bus.wb_fwd_we = 1;
        @(negedge clk);
        chk("store_data fwd", bus.ex_store_data, 32'hABCD);
        next();

        // ALU patterns
        rtype(FUNCT_SUBU, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        look("subu", 32'hFFFF_FFFE);
        rtype(FUNCT_SRA, 5'd0, 5'd2, 5'd3, 32'd0, 32'h8000_0000);
        bus.ex_extended_beq_offset = 32'h0000_0100;   // shamt 4
        look("sra", 32'hF800_0000);
        rtype(FUNCT_SLLV, 5'd1, 5'd2, 5'd3, 32'd3, 32'd1);
        look("sllv", 32'd8);
        rtype(FUNCT_SLT, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1);
        look("slt", 32'd1);
        rtype(FUNCT_SLTU, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1);
        look("sltu", 32'd0);
        rtype(FUNCT_NOR, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0);
        look("nor", 32'hFFFF_FFFF);
        rtype(6'h3F, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9);
        look("unknown funct", 32'd0);
        nop();
        bus.ex_alu_op = ALUOP_LUI; bus.ex_extended_beq_offset = 32'h1234;
        look("lui", 32'h1234_0000);
        nop();
        bus.ex_alu_op = ALUOP_OR; bus.ex_rs = 5'd1; bus.ex_dato_1 = 32'h0F00;
        bus.ex_extended_beq_offset = 32'h00F0;
        look("ori", 32'h0FF0);

        // Link path
        nop();
        bus.ex_isJal = 1; bus.ex_pc_plus_8 = 32'h108; bus.ex_rd = 9;
        @(negedge clk);
        chk("jal result", bus.ex_alu_result, 32'h108);
        chk("jal write_reg", {27'd0, bus.ex_write_reg}, 32'd31);
        next();
        bus.ex_jalSel = 1;
        @(negedge clk);
        chk("jalr write_reg", {27'd0, bus.ex_write_reg}, 32'd9);
        next();
        nop();

        // Mult/div
        run_md("mult", FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, -1);
        run_md("div", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
        run_md("div ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, -1);
        run_md("divu by0", FUNCT_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 33, -1);

        // MTHI followed by MFHI
        rtype(FUNCT_MTHI, 5'd1, 5'd0, 5'd0, 32'hCAFE, 32'd0);
        next();
        rtype(FUNCT_MFHI, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        look("mthi/mfhi", 32'hCAFE);

        // Reset in the middle of DIVU
        rtype(FUNCT_DIVU, 5'd1, 5'd2, 5'd0, 32'd100, 32'd7);
        next();
        rtype(FUNCT_MFHI, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        repeat (10) next();
        reset = 1'b0;
        @(negedge clk);
        chk("reset mid busy", {31'd0, bus.md_busy}, 32'd0);
        chk("reset mid stall", {31'd0, bus.ex_stall}, 32'd0);
        next();
        reset = 1'b1;
        look("mfhi after reset", 32'd0);
        repeat (40) next();
        look("mfhi no late write", 32'd0);
        nop();

        // Freeze for 5 cycles mid-MULTU
        run_md("mult gated", FUNCT_MULTU, 32'd5, 32'd7, 32'd0, 32'd35, 38, 8);

        next();
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Contains the operand forwarding muxes, the ALU, destination-register select and the JAL/JALR link path.
- Contains an iterative multiply/divide unit with HI/LO registers, driven by a 4-state FSM.
- Asserts ex_stall toward the hazard unit while a HI/LO-dependent instruction waits on a busy mult/div.

Parameters:
- DATA_W, 32, datapath width
- MD_ITER, 32, mult/div iterations (one bit per cycle)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- clk_en  in  1  debug step enable; 0 freezes all state
- ex_dato_1  in  32  rs value from ID/EX
- ex_dato_2  in  32  rt value from ID/EX
- ex_rs, ex_rt, ex_rd  in  5 each  register indices
- ex_function_code  in  6  R-type funct
- ex_extended_beq_offset  in  32  sign-extended immediate; [10:6] is shamt
- ex_reg_dst, ex_alu_src  in  1 each  dest select (1=rd); operand B select (1=immediate)
- ex_alu_op  in  4  ALU operation class
- ex_isJal, ex_jalSel  in  1 each  link instruction; 1=JALR (link to rd)
- ex_pc_plus_8  in  32  link value
- mem_fwd_data  in  32  EX/MEM result
- mem_fwd_rd  in  5  EX/MEM destination
- mem_fwd_we  in  1  EX/MEM reg write
- wb_fwd_data, wb_fwd_rd, wb_fwd_we  in  32/5/1  MEM/WB equivalents
- ex_alu_result  out  32  result to EX/MEM
- ex_store_data  out  32  forwarded rt for stores
- ex_write_reg  out  5  destination index
- ex_stall  out  1  freeze request to hazard unit
- md_busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset=0): FSM=IDLE, HI=LO=0, counter=0, md_busy=0, ex_stall=0. ALU outputs are combinational and follow the inputs even during reset.
- Forwarding, per operand:
  - Use MEM when mem_fwd_we && mem_fwd_rd!=0 && mem_fwd_rd==src.
  - Else use WB under the same rule.
  - Else use ex_dato_1 / ex_dato_2.
  - MEM has priority over WB.
- Operand B = ex_alu_src ? immediate : forwarded rt. ex_store_data = forwarded rt.
- ALU op classes (ALUOP_*): ADD, AND, OR, XOR, SLT, SLTU, LUI (imm<<16), RTYPE (decoded by funct).
- RTYPE funct set: ADDU/ADD, SUBU/SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, MFHI, MFLO.
  - Variable shifts use rs[4:0].
  - No overflow traps.
  - Unknown op/funct gives result 0.
- Link: ex_isJal forces ex_alu_result=ex_pc_plus_8.
- ex_write_reg:
  - JAL: 31.
  - JALR: ex_rd.
  - Otherwise: ex_reg_dst ? ex_rd : ex_rt.
- HI/LO access: MTHI/MTLO write HI/LO at the clock edge when clk_en=1 and not stalled. They write 0 to ex_write_reg's file slot; the control path handles that.
- FSM states:
  - IDLE: on a MULT/MULTU/DIV/DIVU in EX with clk_en=1, latch |a| and |b| (unsigned ops: raw values), latch the sign flags, counter=0, go to MUL or DIV. The issuing instruction itself does not stall.
  - MUL: shift-add one bit per cycle. Go to FIX when counter==MD_ITER-1.
  - DIV: restoring divide, one bit per cycle. Same exit condition as MUL.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- Signed-op sign correction:
  - Product negated if signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Latency: issue edge plus MD_ITER+1 cycles. HI/LO are valid on the edge leaving FIX. MFHI/MFLO in the first cycle after that edge sees the new value.
- ex_stall = md_busy && funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU} && ex_alu_op==RTYPE && !ex_isJal. It is combinational and drops in the cycle after FIX.
- Divide special cases:
  - By zero: LO=0xFFFFFFFF, HI=dividend. Completes in normal latency.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- clk_en=0: state, counter, partials and HI/LO all hold. ex_stall is still computed.
- Reset mid-operation: abort to IDLE, HI/LO cleared, no partial write.

Decomposition:
- Shared package mips_pkg:
  - ALUOP_* 4-bit codes.
  - FUNCT_* 6-bit codes (SLL=00, SRL=02, SRA=03, MFHI=10, MTHI=11, MFLO=12, MTLO=13, MULT=18, MULTU=19, DIV=1A, DIVU=1B, ADDU=21, SUBU=23, AND=24, OR=25, XOR=26, NOR=27, SLT=2A, SLTU=2B).
  - md_state_t: IDLE/MUL/DIV/FIX.
- One sub-module: mult_div_unit (FSM, counter, HI/LO, md_busy). ex_stage instantiates it alongside the combinational ALU/forwarding.

Test Plan:
- Forwarding: rs=5, mem_fwd_rd=5 (0x10, we), wb_fwd_rd=5 (0x20, we), RTYPE ADDU with rt=0 -> result 0x10. Drop mem_fwd_we -> 0x20. rd=0 forward -> ignored.
- MULT 0xFFFFFFFE × 3, then MFHI held in EX -> ex_stall=1 for 33 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO returns 0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- JAL with pc_plus_8=0x108 -> result 0x108, write_reg 31. JALR rd=9 -> write_reg 9.
- Drive reset=0 at iteration 10 of DIVU -> md_busy=0, stall=0, MFHI=0 after release. Lower clk_en for 5 cycles mid-MULT -> completion delayed exactly 5 cycles.
